// File: rtl/lights_pkg.sv
// Shared types and default constants for the vehicle lamp controllers.
package lights_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEQ_L = 3'd1,
    SEQ_R = 3'd2,
    DARK  = 3'd3,
    HAZ   = 3'd4
  } turn_state_e;

  localparam int SEG_DEFAULT       = 4;
  localparam int TICK_DIV_DEFAULT  = 50000;
  localparam int COMFORT_N_DEFAULT = 3;

  // side 0 animates the left rear cluster, side 1 the right one
  function automatic turn_state_e seq_of(input logic side);
    return side ? SEQ_R : SEQ_L;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Animation prescaler: tick is high for one cycle when the count reaches
// TICK_DIV-1; clr forces the count back to zero.
module tick_gen
  import lights_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;

  assign tick = (cnt_r == LAST);

  // prescaler count, wraps to zero after the tick cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr || tick) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// Sequential rear turn indicator with hazard and brake overlay.
// Define TURN_COMFORT_BLINK_EN to complete COMFORT_N sequences after a short request.
module turn_sequencer
  import lights_pkg::*;
#(
  parameter int SEG       = SEG_DEFAULT,
  parameter int TICK_DIV  = TICK_DIV_DEFAULT,
  parameter int COMFORT_N = COMFORT_N_DEFAULT
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           left,
  input  logic           right,
  input  logic           brake,
  output logic [SEG-1:0] rear_left,
  output logic [SEG-1:0] rear_right,
  output logic           front_left,
  output logic           front_right,
  output logic           active
);

  localparam logic [3:0] SEG_K = 4'(SEG);

  turn_state_e state_r, state_s;
  logic [3:0]  k_r, k_s;
  logic        side_r, side_s;
  logic        phase_r, phase_s;

  logic haz_req_s, cur_req_s, opp_req_s;
  logic again_s, drop_s;
  logic tick_s, clr_s;

  logic [SEG-1:0] mask_s;
  logic [SEG-1:0] rear_left_s, rear_right_s;
  logic           front_left_s, front_right_s, active_s;

  assign haz_req_s = left & right;
  assign cur_req_s = side_r ? right : left;
  assign opp_req_s = side_r ? left : right;

  // idle holds the prescaler at zero; any state change restarts the step period
  assign clr_s = (state_r == IDLE) || (state_s != state_r);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .CLK  (CLK),
    .RST_N(RST_N),
    .clr  (clr_s),
    .tick (tick_s)
  );

`ifdef TURN_COMFORT_BLINK_EN
  localparam logic [2:0] COMFORT_C = 3'(COMFORT_N);

  logic [2:0] cyc_r;
  logic       fresh_s;

  assign fresh_s = (state_r == IDLE) || (side_s != side_r) || (state_s == HAZ);

  // completed sequences since the request began, saturating at 7
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cyc_r <= 3'd0;
    end else if (fresh_s) begin
      cyc_r <= 3'd0;
    end else if ((state_s == DARK) && (state_r != DARK) && (cyc_r != 3'd7)) begin
      cyc_r <= cyc_r + 3'd1;
    end else begin
      cyc_r <= cyc_r;
    end
  end

  assign again_s = cur_req_s || (cyc_r < COMFORT_C);
  assign drop_s  = 1'b0;
`else
  assign again_s = cur_req_s;
  assign drop_s  = ~cur_req_s;
`endif

  // state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
      k_r     <= 4'd0;
      side_r  <= 1'b0;
      phase_r <= 1'b0;
    end else begin
      state_r <= state_s;
      k_r     <= k_s;
      side_r  <= side_s;
      phase_r <= phase_s;
    end
  end

  // next-state logic; hazard beats side change, which beats a dropped request
  always_comb begin
    state_s = state_r;
    k_s     = k_r;
    side_s  = side_r;
    phase_s = phase_r;
    case (state_r)
      IDLE: begin
        if (haz_req_s) begin
          state_s = HAZ;
          phase_s = 1'b1;
          k_s     = 4'd0;
        end else if (right) begin
          state_s = SEQ_R;
          side_s  = 1'b1;
          k_s     = 4'd1;
        end else if (left) begin
          state_s = SEQ_L;
          side_s  = 1'b0;
          k_s     = 4'd1;
        end else begin
          k_s     = 4'd0;
        end
      end
      SEQ_L, SEQ_R, DARK: begin
        if (haz_req_s) begin
          state_s = HAZ;
          phase_s = 1'b1;
          k_s     = 4'd0;
        end else if (opp_req_s && !cur_req_s) begin
          side_s  = ~side_r;
          state_s = seq_of(~side_r);
          k_s     = 4'd1;
        end else if (drop_s) begin
          state_s = IDLE;
          k_s     = 4'd0;
        end else if (!tick_s) begin
          k_s     = k_r;
        end else if (state_r == DARK) begin
          if (again_s) begin
            state_s = seq_of(side_r);
            k_s     = 4'd1;
          end else begin
            state_s = IDLE;
            k_s     = 4'd0;
          end
        end else if (k_r == SEG_K) begin
          state_s = DARK;
        end else begin
          k_s     = k_r + 4'd1;
        end
      end
      HAZ: begin
        if (!haz_req_s) begin
          state_s = IDLE;
          phase_s = 1'b0;
        end else if (tick_s) begin
          phase_s = ~phase_r;
        end else begin
          phase_s = phase_r;
        end
      end
      default: begin
        state_s = IDLE;
        k_s     = 4'd0;
        phase_s = 1'b0;
      end
    endcase
  end

  // lamp pattern for the upcoming state; brake fills any side not being animated
  always_comb begin
    mask_s = {SEG{1'b0}};
    for (int i = 0; i < SEG; i++) begin
      mask_s[i] = (4'(i) < k_s);
    end
    rear_left_s   = {SEG{brake}};
    rear_right_s  = {SEG{brake}};
    front_left_s  = 1'b0;
    front_right_s = 1'b0;
    active_s      = (state_s != IDLE);
    case (state_s)
      IDLE: begin
        front_left_s  = 1'b0;
        front_right_s = 1'b0;
      end
      SEQ_L: begin
        rear_left_s  = mask_s;
        front_left_s = 1'b1;
      end
      SEQ_R: begin
        rear_right_s  = mask_s;
        front_right_s = 1'b1;
      end
      DARK: begin
        if (side_s) begin
          rear_right_s = {SEG{1'b0}};
        end else begin
          rear_left_s  = {SEG{1'b0}};
        end
      end
      HAZ: begin
        rear_left_s   = {SEG{phase_s}};
        rear_right_s  = {SEG{phase_s}};
        front_left_s  = phase_s;
        front_right_s = phase_s;
      end
      default: begin
        rear_left_s  = {SEG{1'b0}};
        rear_right_s = {SEG{1'b0}};
        active_s     = 1'b0;
      end
    endcase
  end

  // registered lamp outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rear_left   <= {SEG{1'b0}};
      rear_right  <= {SEG{1'b0}};
      front_left  <= 1'b0;
      front_right <= 1'b0;
      active      <= 1'b0;
    end else begin
      rear_left   <= rear_left_s;
      rear_right  <= rear_right_s;
      front_left  <= front_left_s;
      front_right <= front_right_s;
      active      <= active_s;
    end
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer with SEG=4, TICK_DIV=4, COMFORT_N=3.
module tb_turn_sequencer;

  localparam int SEG = 4;

  logic           CLK   = 1'b0;
  logic           RST_N = 1'b0;
  logic           left  = 1'b0;
  logic           right = 1'b0;
  logic           brake = 1'b0;
  logic [SEG-1:0] rear_left, rear_right;
  logic           front_left, front_right, active;

  int vec  = 0;
  int miss = 0;

  // {rear_left, rear_right, front_left, front_right, active}
  logic [10:0] obs;
  assign obs = {rear_left, rear_right, front_left, front_right, active};

  logic [3:0] pat [5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000};

  turn_sequencer #(
    .SEG      (4),
    .TICK_DIV (4),
    .COMFORT_N(3)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .left       (left),
    .right      (right),
    .brake      (brake),
    .rear_left  (rear_left),
    .rear_right (rear_right),
    .front_left (front_left),
    .front_right(front_right),
    .active     (active)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    left  = 1'b0;
    right = 1'b0;
    brake = 1'b0;
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #12;
    vec++;
    if (obs !== 11'b0000_0000_000) begin
      miss++;
      $display("FAIL reset_hold obs=%b expected %b", obs, 11'b0000_0000_000);
    end
    RST_N = 1'b1;
    step(1);
    vec++;
    if (obs !== 11'b0000_0000_000) begin
      miss++;
      $display("FAIL reset_idle obs=%b expected %b", obs, 11'b0000_0000_000);
    end
  endtask

  task automatic test_right_hold();
    logic [3:0]  p;
    logic [10:0] exp;
    do_reset();
    right = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      step(1);
      p   = pat[((n - 1) / 4) % 5];
      exp = {4'b0000, p, 1'b0, (p != 4'b0000), 1'b1};
      vec++;
      if (obs !== exp) begin
        miss++;
        $display("FAIL right_hold edge %0d obs=%b expected %b", n, obs, exp);
      end
    end
    right = 1'b0;
  endtask

  task automatic test_comfort();
    logic [3:0]  p;
    logic [10:0] exp;
    do_reset();
    left = 1'b1;
    step(1);
    vec++;
    if (obs !== 11'b0001_0000_101) begin
      miss++;
      $display("FAIL comfort_start obs=%b expected %b", obs, 11'b0001_0000_101);
    end
    step(1);
    left = 1'b0;
    vec++;
    if (obs !== 11'b0001_0000_101) begin
      miss++;
      $display("FAIL comfort_edge2 obs=%b expected %b", obs, 11'b0001_0000_101);
    end
`ifdef TURN_COMFORT_BLINK_EN
    for (int n = 3; n <= 62; n++) begin
      step(1);
      if (n <= 60) begin
        p   = pat[((n - 1) / 4) % 5];
        exp = {p, 4'b0000, (p != 4'b0000), 1'b0, 1'b1};
      end else begin
        exp = 11'b0000_0000_000;
      end
      vec++;
      if (obs !== exp) begin
        miss++;
        $display("FAIL comfort_seq edge %0d obs=%b expected %b", n, obs, exp);
      end
    end
`else
    for (int n = 3; n <= 5; n++) begin
      step(1);
      vec++;
      if (obs !== 11'b0000_0000_000) begin
        miss++;
        $display("FAIL release_idle edge %0d obs=%b expected %b", n, obs, 11'b0000_0000_000);
      end
    end
`endif
  endtask

  task automatic test_hazard();
    do_reset();
    right = 1'b1;
    step(5);
    vec++;
    if (obs !== 11'b0000_0011_011) begin
      miss++;
      $display("FAIL haz_pre_k2 obs=%b expected %b", obs, 11'b0000_0011_011);
    end
    left = 1'b1;
    step(1);
    vec++;
    if (obs !== 11'b1111_1111_111) begin
      miss++;
      $display("FAIL haz_entry obs=%b expected %b", obs, 11'b1111_1111_111);
    end
    step(3);
    vec++;
    if (obs !== 11'b1111_1111_111) begin
      miss++;
      $display("FAIL haz_on_hold obs=%b expected %b", obs, 11'b1111_1111_111);
    end
    step(1);
    vec++;
    if (obs !== 11'b0000_0000_001) begin
      miss++;
      $display("FAIL haz_off obs=%b expected %b", obs, 11'b0000_0000_001);
    end
    step(4);
    vec++;
    if (obs !== 11'b1111_1111_111) begin
      miss++;
      $display("FAIL haz_on_again obs=%b expected %b", obs, 11'b1111_1111_111);
    end
    right = 1'b0;
    step(1);
    vec++;
    if (obs !== 11'b0000_0000_000) begin
      miss++;
      $display("FAIL haz_exit obs=%b expected %b", obs, 11'b0000_0000_000);
    end
    left = 1'b0;
  endtask

  task automatic test_brake();
    do_reset();
    left  = 1'b1;
    brake = 1'b1;
    step(1);
    vec++;
    if (obs !== 11'b0001_1111_101) begin
      miss++;
      $display("FAIL brake_seq_k1 obs=%b expected %b", obs, 11'b0001_1111_101);
    end
    step(4);
    vec++;
    if (obs !== 11'b0011_1111_101) begin
      miss++;
      $display("FAIL brake_seq_k2 obs=%b expected %b", obs, 11'b0011_1111_101);
    end
    step(12);
    vec++;
    if (obs !== 11'b0000_1111_001) begin
      miss++;
      $display("FAIL brake_dark obs=%b expected %b", obs, 11'b0000_1111_001);
    end
    do_reset();
    brake = 1'b1;
    step(1);
    vec++;
    if (obs !== 11'b1111_1111_000) begin
      miss++;
      $display("FAIL brake_idle obs=%b expected %b", obs, 11'b1111_1111_000);
    end
    brake = 1'b0;
    step(1);
    vec++;
    if (obs !== 11'b0000_0000_000) begin
      miss++;
      $display("FAIL brake_release obs=%b expected %b", obs, 11'b0000_0000_000);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    left  = 1'b1;
    right = 1'b1;
    step(3);
    vec++;
    if (obs !== 11'b1111_1111_111) begin
      miss++;
      $display("FAIL mid_haz_on obs=%b expected %b", obs, 11'b1111_1111_111);
    end
    #3;
    RST_N = 1'b0;
    #1;
    vec++;
    if (obs !== 11'b0000_0000_000) begin
      miss++;
      $display("FAIL mid_async_reset obs=%b expected %b", obs, 11'b0000_0000_000);
    end
    left = 1'b0;
    #2;
    RST_N = 1'b1;
    step(1);
    vec++;
    if (obs !== 11'b0000_0001_011) begin
      miss++;
      $display("FAIL mid_first_edge obs=%b expected %b", obs, 11'b0000_0001_011);
    end
    right = 1'b0;
  endtask

  task automatic test_abort_dark();
    do_reset();
    left = 1'b1;
    step(17);
    vec++;
    if (obs !== 11'b0000_0000_001) begin
      miss++;
      $display("FAIL abort_in_dark obs=%b expected %b", obs, 11'b0000_0000_001);
    end
    left  = 1'b0;
    right = 1'b1;
    step(1);
    vec++;
    if (obs !== 11'b0000_0001_011) begin
      miss++;
      $display("FAIL abort_switch obs=%b expected %b", obs, 11'b0000_0001_011);
    end
    step(4);
    vec++;
    if (obs !== 11'b0000_0011_011) begin
      miss++;
      $display("FAIL abort_continue obs=%b expected %b", obs, 11'b0000_0011_011);
    end
    right = 1'b0;
  endtask

  initial begin
    test_reset();
    test_right_hold();
    test_comfort();
    test_hazard();
    test_brake();
    test_reset_mid();
    test_abort_dark();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/turn_sequencer.md
TURN_SEQUENCER -- requirements
Module: turn_sequencer

Interface
REQ-001 SHALL have parameter SEG, default 4: lamp segments per rear side (2..8).
REQ-002 SHALL have parameter TICK_DIV, default 50000: CLK cycles per animation step (>=2).
REQ-003 SHALL have parameter COMFORT_N, default 3: number of full sequences guaranteed after a short request (1..7).
REQ-004 SHALL have port CLK  in  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST_N  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port left  in  1: left turn request, level.
REQ-007 SHALL have port right  in  1: right turn request, level; left and right both high means hazard.
REQ-008 SHALL have port brake  in  1: brake pedal, level.
REQ-009 SHALL have port rear_left  out  SEG: left rear segments; bit0 is innermost.
REQ-010 SHALL have port rear_right  out  SEG: right rear segments; bit0 is innermost.
REQ-011 SHALL have port front_left  out  1: left front indicator.
REQ-012 SHALL have port front_right  out  1: right front indicator.
REQ-013 SHALL have port active  out  1: high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL register all outputs (no combinational input-to-output path).
REQ-015 SHALL implement a prescaler that counts 0..TICK_DIV-1, is held at 0 in IDLE, and pulses tick when the count is TICK_DIV-1 (then wraps to 0).
REQ-016 SHALL implement FSM states IDLE, SEQ_L, SEQ_R, DARK, HAZ.
REQ-017 IDLE SHALL transition as follows: left&right -> HAZ; else right -> SEQ_R; else left -> SEQ_L. The step index k SHALL be set to 1 and the cycle count to 0.
REQ-018 SEQ_x SHALL light the low k bits of the active rear side and the front lamp of that side; k SHALL increment on each tick.
REQ-019 On a tick with k==SEG, SEQ_x SHALL go to DARK and increment the cycle count (saturating at 7).
REQ-020 DARK SHALL drive that side's rear lamps and front lamp to 0 for one tick period.
REQ-021 On the tick that ends DARK, the FSM SHALL go back to SEQ_x with k=1 if the request is still high or the cycle count is below COMFORT_N; otherwise it SHALL go to IDLE.
REQ-022 HAZ SHALL alternate, one tick period per phase, between all rear segments plus both fronts ON and everything OFF, starting with ON.
REQ-023 HAZ SHALL be left on the next edge after left&right are no longer both high, going to IDLE.
REQ-024 left&right high in any non-HAZ state SHALL enter HAZ on the next edge, with phase ON and the prescaler cleared.
REQ-025 If the opposite request rises while the current one is low during SEQ_x or DARK, the FSM SHALL abort and enter the opposite SEQ on the next edge with k=1, cycle count 0, and the prescaler cleared.
REQ-026 When brake is high, every rear side not driven by SEQ_x, DARK or HAZ SHALL show all SEG bits set; the side being animated and HAZ SHALL override brake.
REQ-027 Brake SHALL have no effect on the front lamps.

Reset
REQ-028 RST_N low SHALL immediately set the FSM to IDLE and set k, cycle count, prescaler and all outputs to 0, including mid-sequence.
REQ-029 After RST_N rises, the first state change SHALL occur on a CLK edge that samples RST_N high.

Configuration
REQ-030 Macro TURN_COMFORT_BLINK_EN, when defined, SHALL enable the COMFORT_N completion rule of REQ-021.
REQ-031 When TURN_COMFORT_BLINK_EN is undefined, the cycle-count term SHALL be removed: a request falling in SEQ_x or DARK SHALL go to IDLE on the next edge with outputs 0, and COMFORT_N SHALL be ignored.

Structure
REQ-032 A shared package lights_pkg SHALL hold the FSM state enum and the default constants for SEG, TICK_DIV and COMFORT_N.
REQ-033 The prescaler SHALL be a sub-module, tick_gen, with parameter TICK_DIV and ports CLK, RST_N, clr and tick.

Verification (SEG=4, TICK_DIV=4, COMFORT_N=3)
REQ-034 Hold right for 40 cycles -> rear_right 0001, 0011, 0111, 1111, 0000 (one phase per 4 cycles, repeating); front_right high except during 0000; left outputs stay 0.
REQ-035 Pulse left for 2 cycles, macro defined -> exactly 3 left sequences (60 cycles), then IDLE and active=0; macro undefined -> IDLE on the next edge after release.
REQ-036 Raise left&right during SEQ_R at k=2 -> next edge: rear_left=1111, rear_right=1111, both fronts on; toggles every 4 cycles; drop right -> IDLE on the next edge.
REQ-037 brake high during a left sequence -> rear_right=1111 steady while rear_left keeps its sequence; brake with no request -> both sides 1111 and fronts 0.
REQ-038 Assert RST_N low mid-HAZ between clock edges -> all outputs 0 immediately; after release, right held -> rear_right=0001 on the first edge.
REQ-039 Release left and raise right during DARK -> SEQ_R with k=1 on the next edge; no further left output.
